rcu_sda_transmitter: RTL
========================

RCU_SDA_TRANSMITTER -- requirements
Module: rcu_sda_transmitter

Interface
REQ-001 SHALL have parameter NBYTES, default 2: bytes per read word; tx_data width is 8*NBYTES.
REQ-002 SHALL have port clk_40m, input, 1: 40 MHz board-controller clock; sole clock.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port rcu_scl, input, 1: already-registered RCU SCL, synchronous to clk_40m.
REQ-005 SHALL have port rcu_sda_in, input, 1: already-registered RCU SDA, synchronous to clk_40m.
REQ-006 SHALL have port tx_start, input, 1: one-cycle request to send tx_data; issued while SCL is low.
REQ-007 SHALL have port tx_data, input, 8*NBYTES: read word, MSB first; sampled only on accepted tx_start.
REQ-008 SHALL have port rcu_sda_out, output, 1: open-drain intent; 0 = pull SDA low, 1 = release.
REQ-009 SHALL have port tx_busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port tx_done, output, 1: one-cycle pulse when the master ACKs the last byte.
REQ-011 SHALL have port tx_nack, output, 1: one-cycle pulse when the master NACKs any byte.
REQ-012 SHALL have port tx_abort, output, 1: one-cycle pulse on START or STOP while busy.

Function
REQ-013 SHALL register rcu_scl and rcu_sda_in once more (scl_q, sda_q) for edge detection.
REQ-014 SHALL define the detected events as follows: fall = scl_q & ~rcu_scl; rise = ~scl_q & rcu_scl; STOP = rcu_scl & scl_q & ~sda_q & rcu_sda_in; START = rcu_scl & scl_q & sda_q & ~rcu_sda_in.
REQ-015 SHALL use the states IDLE, SHIFT, ACK, WAIT_FALL.
REQ-016 SHALL, in IDLE, accept tx_start: load the shift register from tx_data, clear bit_cnt (3 bits) and byte_cnt, enter SHIFT, and drive the MSB on rcu_sda_out in the next cycle.
REQ-017 SHALL ignore tx_start while tx_busy=1; it SHALL have no effect on the shift register or counters.
REQ-018 SHALL, in SHIFT, left-shift and drive the next bit one clk_40m cycle after each fall; rcu_sda_out SHALL NOT change at any other time.
REQ-019 SHALL, on the 8th fall of a byte (bit_cnt wraps 7->0), set rcu_sda_out=1 in the same update and enter ACK.
REQ-020 SHALL, in ACK, sample rcu_sda_in on rise: 0 = ACK, 1 = NACK; then enter WAIT_FALL.
REQ-021 SHALL, on ACK with byte_cnt<NBYTES-1: increment byte_cnt, then drive the next byte's MSB one cycle after the next fall and return to SHIFT.
REQ-022 SHALL, on ACK of the last byte: pulse tx_done on the cycle after rise, keep SDA released, and go to IDLE at the next fall.
REQ-023 SHALL, on NACK: pulse tx_nack on the cycle after rise, keep SDA released, and go to IDLE at the next fall.
REQ-024 SHALL, on START or STOP in any non-IDLE state: pulse tx_abort, set rcu_sda_out=1, and go to IDLE in the next cycle; abort SHALL take priority over fall/rise in the same cycle.
REQ-025 SHALL, while SDA is being driven, mask START/STOP detection caused by its own driven value; only a rcu_sda_in edge while SCL is high and sda_q differs from the driven value SHALL count.
REQ-026 SHALL ensure that tx_done, tx_nack and tx_abort are mutually exclusive and never assert in the same cycle.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force: state IDLE, rcu_sda_out=1, tx_busy/tx_done/tx_nack/tx_abort=0, counters and shift register 0, scl_q=1, sda_q=1.
REQ-028 SHALL, on reset mid-transfer, release SDA immediately without a completion or abort pulse.

Structure
REQ-029 SHALL place the state encoding and the BITS_PER_BYTE=8 constant in a shared package, rcu_bus_pkg.
REQ-030 SHALL implement START/STOP/rise/fall generation as one sub-module, rcu_bus_edge_det, reusable by the receive path.

Verification
REQ-031 SHALL verify: tx_data=16'hA55A, master ACKs both bytes -> SDA bits 1010_0101 then 0101_1010; tx_done pulses once; tx_busy falls at the next fall.
REQ-032 SHALL verify: tx_data=16'hFF00, master NACKs byte 0 -> tx_nack pulses; SDA stays 1 through byte 1's 8 clocks; tx_done never asserts.
REQ-033 SHALL verify: STOP injected after bit 3 of byte 1 -> tx_abort pulses 1 cycle; rcu_sda_out=1 next cycle; state IDLE.
REQ-034 SHALL verify: second tx_start during a transfer with tx_data=16'h1234 -> output stream unchanged from the first word.
REQ-035 SHALL verify: rst_n low during bit 5 while SDA=0 -> rcu_sda_out=1 with no clock edge needed; no pulse outputs.
REQ-036 SHALL verify: 1-cycle SCL high pulse (40 MHz) -> the bit advances exactly once, with no double shift.

Source files
------------

// File: rtl/rcu_bus_pkg.sv
// Shared definitions for the RCU serial-bus transmit/receive paths.
package rcu_bus_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int BIT_CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        ACK       = 2'd2,
        WAIT_FALL = 2'd3
    } tx_state_t;

    // True on the bit count of the final data bit of a byte.
    function automatic logic last_bit(input logic [BIT_CNT_W-1:0] cnt);
        return cnt == BIT_CNT_W'(BITS_PER_BYTE - 1);
    endfunction

endpackage

// File: rtl/rcu_bus_edge_det.sv
// SCL edge and START/STOP condition detector for the RCU bus.
// Inputs are already synchronous to clk_40m; one more register stage gives
// the previous-cycle view needed for edge detection.
module rcu_bus_edge_det (
    input  logic clk_40m,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    input  logic sda_drive_low,
    output logic scl_fall,
    output logic scl_rise,
    output logic bus_start,
    output logic bus_stop
);

    logic scl_q;
    logic sda_q;
    logic own_edge;

    // Previous-cycle copies of the bus lines; idle bus is high.
    always_ff @(posedge clk_40m or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl;
            sda_q <= sda;
        end
    end

    // While we pull SDA low, a line value equal to our own drive is not a
    // master-generated condition and must not be reported.
    assign own_edge  = sda_drive_low & ~sda;

    assign scl_fall  = scl_q & ~scl;
    assign scl_rise  = ~scl_q & scl;
    assign bus_stop  = scl & scl_q & ~sda_q & sda & ~own_edge;
    assign bus_start = scl & scl_q & sda_q & ~sda & ~own_edge;

endmodule

// File: rtl/rcu_sda_transmitter.sv
// RCU slave read-data transmitter: shifts an NBYTES word out on SDA, MSB
// first, one bit per SCL low phase, and checks the master ACK per byte.
module rcu_sda_transmitter
    import rcu_bus_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                    clk_40m,
    input  logic                    rst_n,
    input  logic                    rcu_scl,
    input  logic                    rcu_sda_in,
    input  logic                    tx_start,
    input  logic [8*NBYTES-1:0]     tx_data,
    output logic                    rcu_sda_out,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic                    tx_nack,
    output logic                    tx_abort
);

    localparam int W          = BITS_PER_BYTE * NBYTES;
    localparam int BYTE_CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(NBYTES - 1);

    tx_state_t              state;
    logic [W-1:0]           sreg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BYTE_CNT_W-1:0]  byte_cnt;
    logic                   more;
    logic                   scl_fall;
    logic                   scl_rise;
    logic                   bus_start;
    logic                   bus_stop;

    rcu_bus_edge_det u_edge_det (
        .clk_40m       (clk_40m),
        .rst_n         (rst_n),
        .scl           (rcu_scl),
        .sda           (rcu_sda_in),
        .sda_drive_low (~rcu_sda_out),
        .scl_fall      (scl_fall),
        .scl_rise      (scl_rise),
        .bus_start     (bus_start),
        .bus_stop      (bus_stop)
    );

    assign tx_busy = (state != IDLE);

    // Transmit FSM: SDA only changes in the cycle after an SCL fall, except
    // on abort, where it is released immediately.
    always_ff @(posedge clk_40m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sreg        <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            more        <= 1'b0;
            rcu_sda_out <= 1'b1;
            tx_done     <= 1'b0;
            tx_nack     <= 1'b0;
            tx_abort    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_nack  <= 1'b0;
            tx_abort <= 1'b0;
            // A master START/STOP mid-transfer wins over any SCL edge.
            if (state != IDLE && (bus_start || bus_stop)) begin
                tx_abort    <= 1'b1;
                rcu_sda_out <= 1'b1;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_start) begin
                            sreg        <= tx_data;
                            bit_cnt     <= '0;
                            byte_cnt    <= '0;
                            more        <= 1'b0;
                            rcu_sda_out <= tx_data[W-1];
                            state       <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (scl_fall) begin
                            sreg    <= {sreg[W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            if (last_bit(bit_cnt)) begin
                                rcu_sda_out <= 1'b1;
                                state       <= ACK;
                            end else begin
                                rcu_sda_out <= sreg[W-2];
                            end
                        end
                    end
                    ACK: begin
                        if (scl_rise) begin
                            state <= WAIT_FALL;
                            if (rcu_sda_in) begin
                                tx_nack <= 1'b1;
                                more    <= 1'b0;
                            end else if (byte_cnt == LAST_BYTE) begin
                                tx_done <= 1'b1;
                                more    <= 1'b0;
                            end else begin
                                byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                                more     <= 1'b1;
                            end
                        end
                    end
                    WAIT_FALL: begin
                        if (scl_fall) begin
                            if (more) begin
                                rcu_sda_out <= sreg[W-1];
                                bit_cnt     <= '0;
                                state       <= SHIFT;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
